idu_decode_buf: RTL and testbench



---
 rtl/idu_pkg.sv | 62 ++++++
 rtl/idu_decode_comb.sv | 193 +++++++++++++++++++
 rtl/idu_decode_buf.sv | 158 +++++++++++++++
 tb/tb_idu_decode_buf.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// -----------------------------------------------------------------------------
// idu_pkg
// Shared definitions for the buffered decode stage (idu_decode_buf):
//   - RV32 major opcode constants
//   - bit positions inside the one-hot decode group vector
//   - fixed instruction encodings for nop and the privileged SYSTEM ops
//   - dec_pkt_t, the decoded instruction record held in the output slot
// Optional build macro used by the decoder: IDU_RV32M_EN (adds mul/div decode).
// -----------------------------------------------------------------------------
package idu_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct7 values for the base integer ISA
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Group vector layout: {sys, mem, csr, muldiv, bjp, alu}
    localparam int IDU_GRP_ALU    = 0;
    localparam int IDU_GRP_BJP    = 1;
    localparam int IDU_GRP_MULDIV = 2;
    localparam int IDU_GRP_CSR    = 3;
    localparam int IDU_GRP_MEM    = 4;
    localparam int IDU_GRP_SYS    = 5;
    localparam int IDU_GRP_W      = 6;

    // Exact encodings recognised as whole words
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] INST_DRET   = 32'h7b20_0073;

    typedef struct packed {
        logic [IDU_GRP_W-1:0] grp;
        logic [31:0]          imm;
        logic [31:0]          addr;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic                 we;
        logic [11:0]          csr_addr;
        logic                 csr_we;
        logic                 illegal;
    } dec_pkt_t;

    function automatic logic [IDU_GRP_W-1:0] grp_onehot(input int idx);
        return IDU_GRP_W'(1) << idx;
    endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// -----------------------------------------------------------------------------
// idu_decode_comb
// Purely combinational RV32I + Zicsr (+ optional RV32M) decoder.
// Ports:
//   inst       in  32  instruction word
//   inst_addr  in  32  instruction address, copied into the packet
//   pkt        out     decoded record (dec_pkt_t)
// Build option: define IDU_RV32M_EN to decode OP/funct7=0000001 as muldiv;
// otherwise those encodings are illegal and the muldiv group bit is tied 0.
// Illegal encodings produce an all-zero packet apart from addr and illegal=1.
// -----------------------------------------------------------------------------
module idu_decode_comb
    import idu_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] inst_addr,
    output dec_pkt_t    pkt
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] f_rs1;
    logic [4:0] f_rs2;
    logic [4:0] f_rd;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign f_rs1  = inst[19:15];
    assign f_rs2  = inst[24:20];
    assign f_rd   = inst[11:7];

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_z;
    logic [31:0] imm_sh;

    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_z  = {27'b0, inst[19:15]};
    assign imm_sh = {27'b0, inst[24:20]};

    logic                 legal;
    logic [IDU_GRP_W-1:0] grp;
    logic [31:0]          imm;
    logic                 use_rs1;
    logic                 use_rs2;
    logic                 use_rd;
    logic                 csr_acc;
    logic                 csr_field;

    always_comb begin
        legal     = 1'b0;
        grp       = '0;
        imm       = '0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        csr_acc   = 1'b0;
        csr_field = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                legal  = 1'b1;
                grp    = grp_onehot(IDU_GRP_ALU);
                imm    = imm_u;
                use_rd = 1'b1;
            end
            OPC_JAL: begin
                legal  = 1'b1;
                grp    = grp_onehot(IDU_GRP_BJP);
                imm    = imm_j;
                use_rd = 1'b1;
            end
            OPC_JALR: begin
                legal   = (funct3 == 3'b000);
                grp     = grp_onehot(IDU_GRP_BJP);
                imm     = imm_i;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_BRANCH: begin
                legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
                grp     = grp_onehot(IDU_GRP_BJP);
                imm     = imm_b;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                legal   = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                grp     = grp_onehot(IDU_GRP_MEM);
                imm     = imm_i;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_STORE: begin
                legal   = funct3 inside {3'b000, 3'b001, 3'b010};
                grp     = grp_onehot(IDU_GRP_MEM);
                imm     = imm_s;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                if (inst == INST_NOP) begin
                    // canonical nop is routed to sys and writes nothing
                    legal = 1'b1;
                    grp   = grp_onehot(IDU_GRP_SYS);
                end else begin
                    case (funct3)
                        3'b001:  legal = (funct7 == F7_BASE);
                        3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        default: legal = 1'b1;
                    endcase
                    grp     = grp_onehot(IDU_GRP_ALU);
                    imm     = (funct3 == 3'b001 || funct3 == 3'b101) ? imm_sh : imm_i;
                    use_rs1 = 1'b1;
                    use_rd  = 1'b1;
                end
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    grp   = grp_onehot(IDU_GRP_ALU);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal = 1'b1;
                    grp   = grp_onehot(IDU_GRP_ALU);
                end
`ifdef IDU_RV32M_EN
                else if (funct7 == 7'b0000001) begin
                    legal = 1'b1;
                    grp   = grp_onehot(IDU_GRP_MULDIV);
                end
`endif
            end
            OPC_MISC_MEM: begin
                // fence / fence.i: no register traffic towards dispatch
                legal = (funct3 == 3'b000) || (funct3 == 3'b001);
                grp   = grp_onehot(IDU_GRP_SYS);
            end
            OPC_SYSTEM: begin
                csr_field = 1'b1;
                if (funct3 == 3'b000) begin
                    legal = inst inside {INST_ECALL, INST_EBREAK, INST_MRET, INST_DRET};
                    grp   = grp_onehot(IDU_GRP_SYS);
                end else if (funct3 == 3'b100) begin
                    legal = 1'b0;
                end else begin
                    legal   = 1'b1;
                    grp     = grp_onehot(IDU_GRP_CSR);
                    csr_acc = 1'b1;
                    use_rd  = 1'b1;
                    // funct3[2] selects the csr*i forms whose rs1 field is a uimm
                    if (funct3[2]) begin
                        imm = imm_z;
                    end else begin
                        use_rs1 = 1'b1;
                    end
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        pkt      = '0;
        pkt.addr = inst_addr;
        if (legal) begin
            pkt.grp      = grp;
            pkt.imm      = imm;
            pkt.rs1      = use_rs1 ? f_rs1 : 5'd0;
            pkt.rs2      = use_rs2 ? f_rs2 : 5'd0;
            pkt.rd       = use_rd ? f_rd : 5'd0;
            pkt.we       = use_rd;
            pkt.csr_addr = csr_field ? inst[31:20] : 12'd0;
            pkt.csr_we   = csr_acc;
        end else begin
            pkt.illegal = 1'b1;
        end
`ifndef IDU_RV32M_EN
        pkt.grp[IDU_GRP_MULDIV] = 1'b0;
`endif
    end

endmodule

// File: rtl/idu_decode_buf.sv
// -----------------------------------------------------------------------------
// idu_decode_buf
// Buffered decode stage: fetched instructions enter a DEPTH-entry queue over a
// valid/ready handshake, the head (or the incoming word when the queue is
// empty) is decoded and captured into a registered output slot.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i             drop queue contents and the output slot
//   inst_valid_i/inst_ready_o, inst_i, inst_addr_i   fetch side
//   dec_valid_o/dec_ready_i                          dispatch side
//   dec_grp_o, dec_imm_o, dec_inst_addr_o, reg1_raddr_o, reg2_raddr_o,
//   reg_waddr_o, reg_we_o, csr_addr_o, csr_we_o, dec_illegal_o  decoded fields
//   fifo_count_o        queue occupancy (output slot not included)
// Build option: IDU_RV32M_EN (see idu_decode_comb).
// -----------------------------------------------------------------------------
module idu_decode_buf
    import idu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              inst_valid_i,
    output logic              inst_ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [5:0]        dec_grp_o,
    output logic [31:0]       dec_imm_o,
    output logic [ADDR_W-1:0] dec_inst_addr_o,
    output logic [4:0]        reg1_raddr_o,
    output logic [4:0]        reg2_raddr_o,
    output logic [4:0]        reg_waddr_o,
    output logic              reg_we_o,
    output logic [11:0]       csr_addr_o,
    output logic              csr_we_o,
    output logic              dec_illegal_o,
    output logic [CNT_W-1:0]  fifo_count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             ready_reg;
    logic             slot_valid_reg;
    dec_pkt_t         slot_reg;

    logic empty;
    logic full_next;
    logic in_fire;
    logic load_en;
    logic pop;
    logic bypass;
    logic push;

    logic [INST_W-1:0] src_inst;
    logic [ADDR_W-1:0] src_addr;
    dec_pkt_t          dec_pkt;

    always_comb begin
        empty   = (wr_ptr_reg == rd_ptr_reg);
        in_fire = inst_valid_i & ready_reg;
        load_en = ~slot_valid_reg | dec_ready_i;
        pop     = load_en & ~empty;
        // bypass keeps program order because it only happens with an empty queue
        bypass  = load_en & empty & in_fire;
        push    = in_fire & ~bypass;

        wr_ptr_next = wr_ptr_reg + PTR_W'(push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        full_next   = (wr_ptr_next[IDX_W] != rd_ptr_next[IDX_W]) &&
                      (wr_ptr_next[IDX_W-1:0] == rd_ptr_next[IDX_W-1:0]);
    end

    // Decoder source: queue head when anything is queued, else the fetch input
    always_comb begin
        if (empty) begin
            src_inst = inst_i;
            src_addr = inst_addr_i;
        end else begin
            src_inst = inst_mem[rd_ptr_reg[IDX_W-1:0]];
            src_addr = addr_mem[rd_ptr_reg[IDX_W-1:0]];
        end
    end

    idu_decode_comb u_decode (
        .inst      (32'(src_inst)),
        .inst_addr (32'(src_addr)),
        .pkt       (dec_pkt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            ready_reg      <= 1'b0;
            slot_valid_reg <= 1'b0;
            slot_reg       <= '0;
        end else if (flush_i) begin
            // any fetch transfer in this cycle is discarded with the rest
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            ready_reg      <= 1'b1;
            slot_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ready_reg  <= ~full_next;
            if (load_en) begin
                slot_valid_reg <= pop | bypass;
                if (pop | bypass) begin
                    slot_reg <= dec_pkt;
                end
            end
        end
    end

    // Queue storage has no reset; contents are only read behind valid pointers
    always_ff @(posedge clk) begin
        if (push && !flush_i && !rst) begin
            inst_mem[wr_ptr_reg[IDX_W-1:0]] <= inst_i;
            addr_mem[wr_ptr_reg[IDX_W-1:0]] <= inst_addr_i;
        end
    end

    assign inst_ready_o    = ready_reg;
    assign dec_valid_o     = slot_valid_reg;
    assign dec_grp_o       = slot_reg.grp;
    assign dec_imm_o       = slot_reg.imm;
    assign dec_inst_addr_o = slot_reg.addr[ADDR_W-1:0];
    assign reg1_raddr_o    = slot_reg.rs1;
    assign reg2_raddr_o    = slot_reg.rs2;
    assign reg_waddr_o     = slot_reg.rd;
    assign reg_we_o        = slot_reg.we;
    assign csr_addr_o      = slot_reg.csr_addr;
    assign csr_we_o        = slot_reg.csr_we;
    assign dec_illegal_o   = slot_reg.illegal;
    assign fifo_count_o    = count_reg;

endmodule

// File: tb/tb_idu_decode_buf.sv
module tb_idu_decode_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [5:0]  dec_grp_o;
    logic [31:0] dec_imm_o;
    logic [31:0] dec_inst_addr_o;
    logic [4:0]  reg1_raddr_o;
    logic [4:0]  reg2_raddr_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [11:0] csr_addr_o;
    logic        csr_we_o;
    logic        dec_illegal_o;
    logic [2:0]  fifo_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idu_decode_buf dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .inst_valid_i    (inst_valid_i),
        .inst_ready_o    (inst_ready_o),
        .inst_i          (inst_i),
        .inst_addr_i     (inst_addr_i),
        .dec_valid_o     (dec_valid_o),
        .dec_ready_i     (dec_ready_i),
        .dec_grp_o       (dec_grp_o),
        .dec_imm_o       (dec_imm_o),
        .dec_inst_addr_o (dec_inst_addr_o),
        .reg1_raddr_o    (reg1_raddr_o),
        .reg2_raddr_o    (reg2_raddr_o),
        .reg_waddr_o     (reg_waddr_o),
        .reg_we_o        (reg_we_o),
        .csr_addr_o      (csr_addr_o),
        .csr_we_o        (csr_we_o),
        .dec_illegal_o   (dec_illegal_o),
        .fifo_count_o    (fifo_count_o)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [5:0]  grp;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [11:0] csr;
        logic        csr_we;
    } dvec_t;

    dvec_t vecs [14];

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0; dec_ready_i = 1'b0;
        inst_i = '0; inst_addr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b want=0", inst_ready_o); end
        checks++; if (dec_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", dec_valid_o); end
        checks++; if (fifo_count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", fifo_count_o); end
        checks++;
        if ({dec_grp_o, dec_imm_o, dec_inst_addr_o, reg_we_o, csr_we_o, dec_illegal_o, reg_waddr_o} !== '0) begin
            failures++; $display("FAIL reset_fields grp=%b imm=%h addr=%h we=%b ill=%b want all 0",
                                 dec_grp_o, dec_imm_o, dec_inst_addr_o, reg_we_o, dec_illegal_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b want=1", inst_ready_o); end
        $display("reset: ready=%0b valid=%0b count=%0d", inst_ready_o, dec_valid_o, fifo_count_o);
    endtask

    task automatic test_single_addi();
        dec_ready_i = 1'b1;
        inst_valid_i = 1'b1; inst_i = 32'h0051_0093; inst_addr_i = 32'h80;
        @(posedge clk); #1;
        inst_valid_i = 1'b0;
        checks++; if (dec_valid_o !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b want=1", dec_valid_o); end
        checks++; if (dec_grp_o !== 6'b000001) begin failures++; $display("FAIL addi_grp got=%b want=000001", dec_grp_o); end
        checks++; if (dec_imm_o !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h want=5", dec_imm_o); end
        checks++; if (reg1_raddr_o !== 5'd2 || reg2_raddr_o !== 5'd0) begin failures++; $display("FAIL addi_rs got=%0d,%0d want=2,0", reg1_raddr_o, reg2_raddr_o); end
        checks++; if (reg_waddr_o !== 5'd1 || reg_we_o !== 1'b1) begin failures++; $display("FAIL addi_rd got=%0d we=%0b want=1 we=1", reg_waddr_o, reg_we_o); end
        checks++; if (dec_inst_addr_o !== 32'h80) begin failures++; $display("FAIL addi_addr got=%h want=80", dec_inst_addr_o); end
        checks++; if (fifo_count_o !== 3'd0) begin failures++; $display("FAIL addi_count got=%0d want=0", fifo_count_o); end
        $display("single addi: valid=%0b grp=%b imm=%0d rd=%0d", dec_valid_o, dec_grp_o, dec_imm_o, reg_waddr_o);
        @(posedge clk); #1;
        checks++; if (dec_valid_o !== 1'b0) begin failures++; $display("FAIL addi_drain got=%0b want=0", dec_valid_o); end
    endtask

    task automatic test_backpressure();
        dec_ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            inst_valid_i = 1'b1;
            inst_i = (32'(k) << 20) | 32'h93;
            inst_addr_i = 32'h100 + 32'(4 * k);
            @(posedge clk); #1;
            checks++; if (fifo_count_o !== 3'(k - 1)) begin failures++; $display("FAIL bp_count k=%0d got=%0d want=%0d", k, fifo_count_o, k - 1); end
            checks++; if (inst_ready_o !== (k < 5)) begin failures++; $display("FAIL bp_ready k=%0d got=%0b want=%0b", k, inst_ready_o, k < 5); end
            checks++; if (dec_valid_o !== 1'b1 || dec_imm_o !== 32'd1) begin failures++; $display("FAIL bp_hold k=%0d valid=%0b imm=%0d want valid=1 imm=1", k, dec_valid_o, dec_imm_o); end
            $display("push %0d: count=%0d ready=%0b", k, fifo_count_o, inst_ready_o);
        end
        inst_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (dec_imm_o !== 32'd1 || dec_inst_addr_o !== 32'h104) begin failures++; $display("FAIL bp_stable imm=%0d addr=%h want imm=1 addr=104", dec_imm_o, dec_inst_addr_o); end
        dec_ready_i = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            @(posedge clk); #1;
            checks++;
            if (dec_valid_o !== 1'b1 || dec_imm_o !== 32'(j) || dec_inst_addr_o !== 32'h100 + 32'(4 * j)) begin
                failures++; $display("FAIL bp_order j=%0d valid=%0b imm=%0d addr=%h want imm=%0d addr=%h",
                                     j, dec_valid_o, dec_imm_o, dec_inst_addr_o, j, 32'h100 + 32'(4 * j));
            end
            checks++; if (fifo_count_o !== 3'(5 - j)) begin failures++; $display("FAIL bp_drain_count j=%0d got=%0d want=%0d", j, fifo_count_o, 5 - j); end
            $display("pop %0d: imm=%0d count=%0d", j, dec_imm_o, fifo_count_o);
        end
        @(posedge clk); #1;
        checks++; if (dec_valid_o !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b want=0", dec_valid_o); end
    endtask

    task automatic test_flush();
        dec_ready_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            inst_valid_i = 1'b1;
            inst_i = (32'(10 + k) << 20) | 32'h93;
            inst_addr_i = 32'h200 + 32'(4 * k);
            @(posedge clk); #1;
        end
        checks++; if (fifo_count_o !== 3'd2) begin failures++; $display("FAIL flush_pre_count got=%0d want=2", fifo_count_o); end
        flush_i = 1'b1;
        inst_i = (32'd9 << 20) | 32'h93; inst_addr_i = 32'h2F0;
        @(posedge clk); #1;
        flush_i = 1'b0; inst_valid_i = 1'b0;
        checks++; if (fifo_count_o !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d want=0", fifo_count_o); end
        checks++; if (dec_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b want=0", dec_valid_o); end
        checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b want=1", inst_ready_o); end
        dec_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (dec_valid_o !== 1'b0) begin failures++; $display("FAIL flush_leak c=%0d addr=%h valid=%0b want valid=0", c, dec_inst_addr_o, dec_valid_o); end
        end
        inst_valid_i = 1'b1; inst_i = (32'd7 << 20) | 32'h93; inst_addr_i = 32'h300;
        @(posedge clk); #1;
        inst_valid_i = 1'b0;
        checks++;
        if (dec_valid_o !== 1'b1 || dec_inst_addr_o !== 32'h300 || dec_imm_o !== 32'd7) begin
            failures++; $display("FAIL flush_after valid=%0b addr=%h imm=%0d want 1/300/7", dec_valid_o, dec_inst_addr_o, dec_imm_o);
        end
        $display("flush: post-flush instruction addr=%h imm=%0d", dec_inst_addr_o, dec_imm_o);
        @(posedge clk); #1;
    endtask

    task automatic test_decode_table();
        vecs[0]  = '{32'h1234_52B7, 6'b000001, 32'h1234_5000, 5'd0, 5'd0, 5'd5, 1'b1, 12'h000, 1'b0};
        vecs[1]  = '{32'h0080_00EF, 6'b000010, 32'h0000_0008, 5'd0, 5'd0, 5'd1, 1'b1, 12'h000, 1'b0};
        vecs[2]  = '{32'h0021_A623, 6'b010000, 32'h0000_000C, 5'd3, 5'd2, 5'd0, 1'b0, 12'h000, 1'b0};
        vecs[3]  = '{32'hFE20_8EE3, 6'b000010, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd0, 1'b0, 12'h000, 1'b0};
        vecs[4]  = '{32'h3002_D273, 6'b001000, 32'h0000_0005, 5'd0, 5'd0, 5'd4, 1'b1, 12'h300, 1'b1};
        vecs[5]  = '{32'h0000_0013, 6'b100000, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 1'b0, 12'h000, 1'b0};
        vecs[6]  = '{32'h0000_0073, 6'b100000, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 1'b0, 12'h000, 1'b0};
        vecs[7]  = '{32'h3020_0073, 6'b100000, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 1'b0, 12'h302, 1'b0};
        vecs[8]  = '{32'h4030_D093, 6'b000001, 32'h0000_0003, 5'd1, 5'd0, 5'd1, 1'b1, 12'h000, 1'b0};
        vecs[9]  = '{32'h0020_81B3, 6'b000001, 32'h0000_0000, 5'd1, 5'd2, 5'd3, 1'b1, 12'h000, 1'b0};
        vecs[10] = '{32'hFF83_A303, 6'b010000, 32'hFFFF_FFF8, 5'd7, 5'd0, 5'd6, 1'b1, 12'h000, 1'b0};
        vecs[11] = '{32'h3053_22F3, 6'b001000, 32'h0000_0000, 5'd6, 5'd0, 5'd5, 1'b1, 12'h305, 1'b1};
        vecs[12] = '{32'h0041_00E7, 6'b000010, 32'h0000_0004, 5'd2, 5'd0, 5'd1, 1'b1, 12'h000, 1'b0};
        vecs[13] = '{32'h0FF0_000F, 6'b100000, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 1'b0, 12'h000, 1'b0};
        dec_ready_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            inst_valid_i = 1'b1; inst_i = vecs[i].inst; inst_addr_i = 32'h400 + 32'(4 * i);
            @(posedge clk); #1;
            checks++;
            if (dec_valid_o !== 1'b1 || dec_illegal_o !== 1'b0 || dec_inst_addr_o !== 32'h400 + 32'(4 * i)) begin
                failures++; $display("FAIL dec_hdr[%0d] valid=%0b ill=%0b addr=%h want 1/0/%h", i, dec_valid_o, dec_illegal_o, dec_inst_addr_o, 32'h400 + 32'(4 * i));
            end
            checks++;
            if (dec_grp_o !== vecs[i].grp || dec_imm_o !== vecs[i].imm) begin
                failures++; $display("FAIL dec_grp_imm[%0d] grp=%b imm=%h want grp=%b imm=%h", i, dec_grp_o, dec_imm_o, vecs[i].grp, vecs[i].imm);
            end
            checks++;
            if (reg1_raddr_o !== vecs[i].rs1 || reg2_raddr_o !== vecs[i].rs2 || reg_waddr_o !== vecs[i].rd || reg_we_o !== vecs[i].we) begin
                failures++; $display("FAIL dec_regs[%0d] rs1=%0d rs2=%0d rd=%0d we=%0b want %0d %0d %0d %0b", i,
                                     reg1_raddr_o, reg2_raddr_o, reg_waddr_o, reg_we_o, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we);
            end
            checks++;
            if (csr_addr_o !== vecs[i].csr || csr_we_o !== vecs[i].csr_we) begin
                failures++; $display("FAIL dec_csr[%0d] csr=%h we=%0b want %h %0b", i, csr_addr_o, csr_we_o, vecs[i].csr, vecs[i].csr_we);
            end
            $display("decode %h: grp=%b imm=%h rs1=%0d rs2=%0d rd=%0d we=%0b", vecs[i].inst, dec_grp_o, dec_imm_o, reg1_raddr_o, reg2_raddr_o, reg_waddr_o, reg_we_o);
        end
        inst_valid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        bad[0] = 32'h0000_007F;
        bad[1] = 32'h3420_C0F3;
        bad[2] = 32'h7E20_81B3;
        dec_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_valid_i = 1'b1; inst_i = bad[i]; inst_addr_i = 32'h500 + 32'(4 * i);
            @(posedge clk); #1;
            checks++;
            if (dec_valid_o !== 1'b1 || dec_illegal_o !== 1'b1) begin
                failures++; $display("FAIL ill_flag[%0d] valid=%0b ill=%0b want 1/1", i, dec_valid_o, dec_illegal_o);
            end
            checks++;
            if (dec_grp_o !== 6'd0 || reg_we_o !== 1'b0 || csr_we_o !== 1'b0 || reg_waddr_o !== 5'd0 || reg1_raddr_o !== 5'd0 || reg2_raddr_o !== 5'd0) begin
                failures++; $display("FAIL ill_fields[%0d] grp=%b we=%0b csr_we=%0b rd=%0d rs1=%0d rs2=%0d want all 0", i,
                                     dec_grp_o, reg_we_o, csr_we_o, reg_waddr_o, reg1_raddr_o, reg2_raddr_o);
            end
            $display("illegal %h: ill=%0b grp=%b", bad[i], dec_illegal_o, dec_grp_o);
        end
        inst_valid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_muldiv();
        dec_ready_i = 1'b1;
        inst_valid_i = 1'b1; inst_i = 32'h0220_81B3; inst_addr_i = 32'h600;
        @(posedge clk); #1;
        inst_valid_i = 1'b0;
`ifdef IDU_RV32M_EN
        checks++;
        if (dec_grp_o !== 6'b000100 || reg_we_o !== 1'b1 || dec_illegal_o !== 1'b0) begin
            failures++; $display("FAIL mul_en grp=%b we=%0b ill=%0b want 000100/1/0", dec_grp_o, reg_we_o, dec_illegal_o);
        end
        checks++;
        if (reg1_raddr_o !== 5'd1 || reg2_raddr_o !== 5'd2 || reg_waddr_o !== 5'd3) begin
            failures++; $display("FAIL mul_regs rs1=%0d rs2=%0d rd=%0d want 1 2 3", reg1_raddr_o, reg2_raddr_o, reg_waddr_o);
        end
`else
        checks++;
        if (dec_illegal_o !== 1'b1 || dec_grp_o !== 6'd0 || reg_we_o !== 1'b0) begin
            failures++; $display("FAIL mul_dis ill=%0b grp=%b we=%0b want 1/000000/0", dec_illegal_o, dec_grp_o, reg_we_o);
        end
`endif
        $display("mul: valid=%0b grp=%b ill=%0b", dec_valid_o, dec_grp_o, dec_illegal_o);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] exp_q [$];
        int          seq = 0;
        int          errs_before;
        logic        in_fire;
        logic        consume;
        errs_before = failures;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            inst_valid_i = ($urandom_range(1) == 1);
            dec_ready_i  = ($urandom_range(1) == 1);
            inst_i       = (32'(seq & 32'h7FF) << 20) | 32'h93;
            inst_addr_i  = 32'h1_0000 + 32'(seq * 4);
            in_fire = inst_valid_i & inst_ready_o;
            consume = dec_valid_o & dec_ready_i;
            if (consume) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rnd_dup cyc=%0d addr=%h want no output", cyc, dec_inst_addr_o);
                end else if (dec_inst_addr_o !== exp_q[0]) begin
                    failures++; $display("FAIL rnd_order cyc=%0d addr=%h want=%h", cyc, dec_inst_addr_o, exp_q[0]);
                end
            end
            @(posedge clk); #1;
            if (consume && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_fire) begin
                exp_q.push_back(32'h1_0000 + 32'(seq * 4));
                seq++;
            end
            checks++;
            if (dec_valid_o !== (exp_q.size() > 0)) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", cyc, dec_valid_o, exp_q.size() > 0);
            end
            checks++;
            if (exp_q.size() > 0 && 32'(fifo_count_o) !== 32'(exp_q.size() - 1)) begin
                failures++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, fifo_count_o, exp_q.size() - 1);
            end
        end
        inst_valid_i = 1'b0;
        dec_ready_i  = 1'b1;
        $display("random: transferred=%0d outstanding=%0d new_failures=%0d", seq, exp_q.size(), failures - errs_before);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_addi();
        test_backpressure();
        test_flush();
        test_decode_table();
        test_illegal();
        test_muldiv();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
